// File: rtl/sram_pkg.sv
// Shared definitions for the scratch/boot SRAM family: size helpers, clear FSM states, clear default.
package sram_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } sram_state_e;

  localparam logic [31:0] SRAM_CLEAR_VALUE = 32'h0000_0000;

  function automatic int unsigned sram_depth(input int unsigned address_width);
    return 32'd1 << address_width;
  endfunction

  function automatic int unsigned sram_be_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Clear engine: walks the whole array once after reset or on request and owns busy meanwhile.
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 13
) (
  input  logic                     sram_clk,
  input  logic                     sram_rst,
  input  logic                     sram_clr,
  output logic                     sram_busy,
  output logic                     clr_we,
  output logic [ADDRESS_WIDTH-1:0] clr_address
);

  sram_state_e state;

  always_ff @(posedge sram_clk) begin
    if (sram_rst) begin
      state       <= ST_CLEAR;
      clr_address <= '0;
      sram_busy   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sram_clr) begin
            state       <= ST_CLEAR;
            clr_address <= '0;
            sram_busy   <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // Requests arriving here are dropped; the walk always runs to DEPTH-1.
          if (clr_address == '1) begin
            state       <= ST_IDLE;
            clr_address <= '0;
            sram_busy   <= 1'b0;
          end else begin
            clr_address <= clr_address + ADDRESS_WIDTH'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          sram_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we = (state == ST_CLEAR);

endmodule

// File: rtl/sram_dp_be.sv
// Dual-port SRAM: port A read/write with byte enables, port B read-only, built-in clear engine.
module sram_dp_be
  import sram_pkg::*;
#(
  parameter int unsigned            ADDRESS_WIDTH = 13,
  parameter int unsigned            DATA_WIDTH    = 32,
  parameter int unsigned            OUT_REG       = 0,
  parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE   = DATA_WIDTH'(SRAM_CLEAR_VALUE)
) (
  input  logic                      sram_clk,
  input  logic                      sram_rst,
  input  logic                      sram_cs_a,
  input  logic                      sram_we_a,
  input  logic [DATA_WIDTH/8-1:0]   sram_be_a,
  input  logic [ADDRESS_WIDTH-1:0]  sram_address_a,
  input  logic [DATA_WIDTH-1:0]     sram_data_i_a,
  output logic [DATA_WIDTH-1:0]     sram_data_o_a,
  output logic                      sram_valid_a,
  input  logic                      sram_cs_b,
  input  logic [ADDRESS_WIDTH-1:0]  sram_address_b,
  output logic [DATA_WIDTH-1:0]     sram_data_o_b,
  output logic                      sram_valid_b,
  input  logic                      sram_clr,
  output logic                      sram_busy
);

  localparam int unsigned DEPTH    = sram_depth(ADDRESS_WIDTH);
  localparam int unsigned BE_WIDTH = sram_be_width(DATA_WIDTH);

  logic                     clr_we;
  logic [ADDRESS_WIDTH-1:0] clr_address;
  logic                     wr_a;
  logic                     rd_a;
  logic                     rd_b;
  logic [DATA_WIDTH-1:0]    s1_data_a;
  logic [DATA_WIDTH-1:0]    s1_data_b;
  logic                     s1_valid_a;
  logic                     s1_valid_b;

  sram_clear_fsm #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_clear_fsm (
    .sram_clk    (sram_clk),
    .sram_rst    (sram_rst),
    .sram_clr    (sram_clr),
    .sram_busy   (sram_busy),
    .clr_we      (clr_we),
    .clr_address (clr_address)
  );

  assign wr_a = !sram_busy && !sram_cs_a && !sram_we_a;
  assign rd_a = !sram_busy && !sram_cs_a &&  sram_we_a;
  assign rd_b = !sram_busy && !sram_cs_b;

  // The array is stored as one 8-bit memory per byte lane so each byte enable maps to its own
  // write port; both read ports see the pre-write word of the same edge (read-first).
  for (genvar g = 0; g < BE_WIDTH; g++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge sram_clk) begin
      if (!sram_rst) begin
        if (clr_we) begin
          lane_mem[clr_address] <= CLEAR_VALUE[8*g +: 8];
        end else if (wr_a && sram_be_a[g]) begin
          lane_mem[sram_address_a] <= sram_data_i_a[8*g +: 8];
        end
      end
    end

    always_ff @(posedge sram_clk) begin
      if (sram_rst) begin
        s1_data_a[8*g +: 8] <= '0;
        s1_data_b[8*g +: 8] <= '0;
      end else begin
        if (rd_a) s1_data_a[8*g +: 8] <= lane_mem[sram_address_a];
        if (rd_b) s1_data_b[8*g +: 8] <= lane_mem[sram_address_b];
      end
    end
  end

  always_ff @(posedge sram_clk) begin
    if (sram_rst) begin
      s1_valid_a <= 1'b0;
      s1_valid_b <= 1'b0;
    end else begin
      s1_valid_a <= rd_a;
      s1_valid_b <= rd_b;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge sram_clk) begin
      if (sram_rst) begin
        sram_data_o_a <= '0;
        sram_data_o_b <= '0;
        sram_valid_a  <= 1'b0;
        sram_valid_b  <= 1'b0;
      end else begin
        sram_valid_a <= s1_valid_a;
        sram_valid_b <= s1_valid_b;
        if (s1_valid_a) sram_data_o_a <= s1_data_a;
        if (s1_valid_b) sram_data_o_b <= s1_data_b;
      end
    end
  end else begin : g_no_out_reg
    assign sram_data_o_a = s1_data_a;
    assign sram_data_o_b = s1_data_b;
    assign sram_valid_a  = s1_valid_a;
    assign sram_valid_b  = s1_valid_b;
  end

endmodule

// File: tb/tb_sram_dp_be.sv
// Scoreboard bench for sram_dp_be: random and directed traffic against a word-array reference model.
module tb_sram_dp_be;

  localparam int unsigned AW      = 5;
  localparam int unsigned DW      = 32;
  localparam int unsigned OUT_REG = 1;
  localparam int unsigned DEPTH   = 1 << AW;
  localparam logic [31:0] CLR_VAL = 32'hDEAD_BEEF;

  logic          sram_clk = 1'b0;
  logic          sram_rst;
  logic          sram_cs_a, sram_we_a;
  logic [3:0]    sram_be_a;
  logic [AW-1:0] sram_address_a;
  logic [31:0]   sram_data_i_a, sram_data_o_a;
  logic          sram_valid_a;
  logic          sram_cs_b;
  logic [AW-1:0] sram_address_b;
  logic [31:0]   sram_data_o_b;
  logic          sram_valid_b;
  logic          sram_clr, sram_busy;

  sram_dp_be #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(OUT_REG), .CLEAR_VALUE(CLR_VAL)
  ) dut (
    .sram_clk(sram_clk), .sram_rst(sram_rst),
    .sram_cs_a(sram_cs_a), .sram_we_a(sram_we_a), .sram_be_a(sram_be_a),
    .sram_address_a(sram_address_a), .sram_data_i_a(sram_data_i_a),
    .sram_data_o_a(sram_data_o_a), .sram_valid_a(sram_valid_a),
    .sram_cs_b(sram_cs_b), .sram_address_b(sram_address_b),
    .sram_data_o_b(sram_data_o_b), .sram_valid_b(sram_valid_b),
    .sram_clr(sram_clr), .sram_busy(sram_busy)
  );

  always #5 sram_clk = ~sram_clk;

  int unsigned cyc = 0;
  logic        rst_q = 1'b0;
  always @(posedge sram_clk) begin
    cyc   <= cyc + 1;
    rst_q <= sram_rst;
  end

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int          n_chk = 0;
  int          n_pass = 0;

  logic [31:0] model [DEPTH];
  int unsigned clr_left = 0;
  bit          pa_en = 0, pb_en = 0;
  logic [31:0] pa_val = '0, pb_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: expected valid/data each cycle; data must hold the last completed read between pulses.
  logic [31:0] last_a = '0, last_b = '0;
  bit          mon_en = 0;
  bit          ev_a, ev_b;
  always @(negedge sram_clk) begin
    if (rst_q) begin
      mon_en = 1;
      qa.delete();
      qb.delete();
      last_a = '0;
      last_b = '0;
    end
    if (mon_en) begin
      ev_a = (qa.size() > 0) && (qa[0].due == cyc);
      chk("valid_a", 32'(sram_valid_a), 32'(ev_a));
      if (ev_a) begin
        last_a = qa[0].data;
        void'(qa.pop_front());
      end
      chk("data_a", sram_data_o_a, last_a);
      ev_b = (qb.size() > 0) && (qb[0].due == cyc);
      chk("valid_b", 32'(sram_valid_b), 32'(ev_b));
      if (ev_b) begin
        last_b = qb[0].data;
        void'(qb.pop_front());
      end
      chk("data_b", sram_data_o_b, last_b);
    end
  end

  // One clock of stimulus; the model decides whether the access is accepted.
  task automatic op(input bit a_cs, input bit a_we, input logic [3:0] be, input logic [AW-1:0] aa,
                    input logic [31:0] din, input bit b_cs, input logic [AW-1:0] ab, input bit clr);
    logic [31:0] m;
    chk("busy", 32'(sram_busy), 32'(clr_left > 0));
    sram_cs_a = a_cs; sram_we_a = a_we; sram_be_a = be; sram_address_a = aa;
    sram_data_i_a = din; sram_cs_b = b_cs; sram_address_b = ab; sram_clr = clr;
    if (clr_left > 0) begin
      clr_left--;
    end else begin
      if (!b_cs) qb.push_back('{pb_en ? pb_val : model[ab], cyc + 1 + OUT_REG});
      if (!a_cs && a_we) qa.push_back('{pa_en ? pa_val : model[aa], cyc + 1 + OUT_REG});
      if (!a_cs && !a_we) begin
        m = '0;
        for (int i = 0; i < 4; i++)
          if (((be >> i) & 4'd1) != 4'd0) m = m | (32'hFF << (8 * i));
        model[aa] = (model[aa] & ~m) | (din & m);
      end
      if (clr) begin
        clr_left = DEPTH;
        foreach (model[i]) model[i] = CLR_VAL;
      end
    end
    pa_en = 0;
    pb_en = 0;
    @(posedge sram_clk);
    #1;
  endtask

  task automatic idle();
    op(1'b1, 1'b1, 4'h0, '0, '0, 1'b1, '0, 1'b0);
  endtask

  task automatic do_reset(input int unsigned cycles);
    sram_rst = 1'b1; sram_cs_a = 1'b1; sram_cs_b = 1'b1; sram_clr = 1'b0;
    repeat (cycles) begin
      @(posedge sram_clk);
      #1;
    end
    sram_rst = 1'b0;
    clr_left = DEPTH;
    foreach (model[i]) model[i] = CLR_VAL;
  endtask

  task automatic run_clear(input int unsigned expect_n);
    int unsigned n = 0;
    while (sram_busy && n < 4 * DEPTH) begin
      idle();
      n++;
    end
    chk("clear_len", n, expect_n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sram_rst = 1'b1; sram_cs_a = 1'b1; sram_we_a = 1'b1; sram_be_a = '0;
    sram_address_a = '0; sram_data_i_a = '0; sram_cs_b = 1'b1; sram_address_b = '0;
    sram_clr = 1'b0;
    do_reset(3);

    // Power-up clear, then corner addresses.
    run_clear(DEPTH);
    pa_en = 1; pa_val = CLR_VAL; op(0, 1, 4'h0, AW'(0), '0, 1, '0, 0);
    pa_en = 1; pa_val = CLR_VAL; op(0, 1, 4'h0, AW'(DEPTH - 1), '0, 1, '0, 0);

    // Byte-enable merge.
    op(0, 0, 4'hF, AW'(5), 32'h1122_3344, 1, '0, 0);
    op(0, 0, 4'b0101, AW'(5), 32'hAABB_CCDD, 1, '0, 0);
    pa_en = 1; pa_val = 32'h11BB_33DD; op(0, 1, 4'h0, AW'(5), '0, 1, '0, 0);

    // Same-address A write / B read returns the old word.
    op(0, 0, 4'hF, AW'(9), 32'h0, 1, '0, 0);
    pb_en = 1; pb_val = 32'h0; op(0, 0, 4'hF, AW'(9), 32'h5, 0, AW'(9), 0);
    pb_en = 1; pb_val = 32'h5; op(1, 1, 4'h0, '0, '0, 0, AW'(9), 0);

    // Back-to-back B reads, then hold while deselected.
    for (int k = 1; k <= 3; k++) op(0, 0, 4'hF, AW'(k), 32'hC0DE_0000 + 32'(k), 1, '0, 0);
    for (int k = 1; k <= 3; k++) begin
      pb_en = 1; pb_val = 32'hC0DE_0000 + 32'(k); op(1, 1, 4'h0, '0, '0, 0, AW'(k), 0);
    end
    repeat (4) idle();
    chk("hold_b", sram_data_o_b, 32'hC0DE_0003);

    // Accesses during a requested clear are dropped.
    op(1, 1, 4'h0, '0, '0, 1, '0, 1);
    op(0, 0, 4'hF, AW'(3), 32'h1234_5678, 0, AW'(3), 0);
    op(0, 1, 4'h0, AW'(4), '0, 1, '0, 1);
    run_clear(DEPTH - 2);
    for (int k = 0; k < int'(DEPTH); k++) begin
      pa_en = 1; pa_val = CLR_VAL; pb_en = 1; pb_val = CLR_VAL;
      op(0, 1, 4'h0, AW'(k), '0, 0, AW'(DEPTH - 1 - k), 0);
    end

    // Reset with reads in flight.
    op(0, 0, 4'hF, AW'(7), 32'h7777_0007, 1, '0, 0);
    op(0, 1, 4'h0, AW'(7), '0, 0, AW'(7), 0);
    do_reset(1);
    chk("rst_valid_a", 32'(sram_valid_a), 32'h0);
    chk("rst_valid_b", 32'(sram_valid_b), 32'h0);
    chk("rst_data_a", sram_data_o_a, 32'h0);
    chk("rst_data_b", sram_data_o_b, 32'h0);
    run_clear(DEPTH);

    // Reset halfway through a clear restarts the full walk.
    op(1, 1, 4'h0, '0, '0, 1, '0, 1);
    repeat (DEPTH / 2) idle();
    do_reset(1);
    run_clear(DEPTH);

    // Random traffic.
    repeat (600) begin
      op(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, 4'($urandom),
         AW'($urandom), $urandom, ($urandom_range(0, 2) == 0), AW'($urandom),
         ($urandom_range(0, 99) == 0));
    end
    repeat (4) idle();
    chk("drain_a", 32'(qa.size()), 32'h0);
    chk("drain_b", 32'(qb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
